// File: rtl/id_stage_pkg.sv
// Shared pipeline definitions: RV32I opcodes, immediate formats, ALU op encoding
// and the decoded control bundle carried from ID into EX.
package id_stage_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    // Low three bits follow funct3; bit 3 is the funct7[5] "alternate" select.
    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SLL    = 4'b0001;
    localparam logic [3:0] ALU_SLT    = 4'b0010;
    localparam logic [3:0] ALU_SLTU   = 4'b0011;
    localparam logic [3:0] ALU_XOR    = 4'b0100;
    localparam logic [3:0] ALU_SRL    = 4'b0101;
    localparam logic [3:0] ALU_OR     = 4'b0110;
    localparam logic [3:0] ALU_AND    = 4'b0111;
    localparam logic [3:0] ALU_SUB    = 4'b1000;
    localparam logic [3:0] ALU_SRA    = 4'b1101;
    localparam logic [3:0] ALU_PASS_B = 4'b1111;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       branch;
        logic       jump;
        logic       illegal;
    } ctrl_t;

    // Sign-extended immediate for a given format; B/J carry an implicit bit 0 of zero.
    function automatic logic [31:0] gen_imm(input logic [31:0] ins, input imm_fmt_e fmt);
        case (fmt)
            IMM_I:   return {{20{ins[31]}}, ins[31:20]};
            IMM_S:   return {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_U:   return {ins[31:12], 12'h000};
            IMM_J:   return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: return 32'h0;
        endcase
    endfunction

    // funct3 -> ALU op; alt selects SUB/SRA where the encoding has one.
    function automatic logic [3:0] alu_from_funct(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// 32x32 integer register file: two combinational read ports with write-through
// bypass, one synchronous write port, x0 hardwired to zero.
module regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    output logic [31:0] rdata1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata2
);

    logic [31:0] regs [32];
    logic        wr_ok;

    assign wr_ok = we && (waddr != 5'd0);

    // Storage: cleared on reset, x0 never written.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wr_ok) begin
            regs[waddr] <= wdata;
        end
    end

    // A write landing this cycle is visible to a same-cycle read of that register.
    assign rdata1 = (raddr1 == 5'd0)               ? 32'h0 :
                    (wr_ok && (waddr == raddr1))   ? wdata : regs[raddr1];
    assign rdata2 = (raddr2 == 5'd0)               ? 32'h0 :
                    (wr_ok && (waddr == raddr2))   ? wdata : regs[raddr2];

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: RV32I decoder, register file read, load-use hazard
// detection and the ID/EX pipeline register.
module id_stage
    import id_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC_PLUS4 = 32'h00000004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_id_pc,
    input  logic [31:0] if_id_instruction,
    input  logic        mem_stall,
    input  logic        id_flush,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        load_use_stall,
    output logic [31:0] id_ex_pc,
    output logic [31:0] id_ex_rs1_data,
    output logic [31:0] id_ex_rs2_data,
    output logic [31:0] id_ex_imm,
    output logic [4:0]  id_ex_rs1,
    output logic [4:0]  id_ex_rs2,
    output logic [4:0]  id_ex_rd,
    output logic [3:0]  id_ex_alu_op,
    output logic        id_ex_alu_src,
    output logic        id_ex_mem_read,
    output logic        id_ex_mem_write,
    output logic        id_ex_reg_write,
    output logic        id_ex_mem_to_reg,
    output logic        id_ex_branch,
    output logic        id_ex_jump,
    output logic        id_ex_illegal
);

    logic [31:0] ins;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    ctrl_t       dec_ctrl;
    imm_fmt_e    imm_fmt;
    logic        use_rs1;
    logic        use_rs2;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        squash;
    ctrl_t       ex_ctrl;

    assign ins    = if_id_instruction;
    assign opcode = ins[6:0];
    assign funct3 = ins[14:12];

    // Opcode decode; anything unrecognised falls out as an illegal NOP.
    always_comb begin
        dec_ctrl = '0;
        imm_fmt  = IMM_NONE;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        case (opcode)
            OPC_LUI: begin
                imm_fmt = IMM_U;  dec_ctrl.alu_op = ALU_PASS_B;
                dec_ctrl.alu_src = 1'b1;  dec_ctrl.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                imm_fmt = IMM_U;  dec_ctrl.alu_op = ALU_ADD;
                dec_ctrl.alu_src = 1'b1;  dec_ctrl.reg_write = 1'b1;
            end
            OPC_JAL: begin
                imm_fmt = IMM_J;  dec_ctrl.alu_op = ALU_ADD;
                dec_ctrl.jump = 1'b1;  dec_ctrl.reg_write = 1'b1;
            end
            OPC_JALR: begin
                imm_fmt = IMM_I;  use_rs1 = 1'b1;  dec_ctrl.alu_op = ALU_ADD;
                dec_ctrl.alu_src = 1'b1;  dec_ctrl.jump = 1'b1;  dec_ctrl.reg_write = 1'b1;
            end
            OPC_BRANCH: begin
                imm_fmt = IMM_B;  use_rs1 = 1'b1;  use_rs2 = 1'b1;
                dec_ctrl.alu_op = ALU_SUB;  dec_ctrl.branch = 1'b1;
            end
            OPC_LOAD: begin
                imm_fmt = IMM_I;  use_rs1 = 1'b1;  dec_ctrl.alu_op = ALU_ADD;
                dec_ctrl.alu_src = 1'b1;  dec_ctrl.mem_read = 1'b1;
                dec_ctrl.reg_write = 1'b1;  dec_ctrl.mem_to_reg = 1'b1;
            end
            OPC_STORE: begin
                imm_fmt = IMM_S;  use_rs1 = 1'b1;  use_rs2 = 1'b1;
                dec_ctrl.alu_op = ALU_ADD;  dec_ctrl.alu_src = 1'b1;  dec_ctrl.mem_write = 1'b1;
            end
            OPC_OP_IMM: begin
                // imm[10] doubles as funct7[5] only for the right-shift encoding
                imm_fmt = IMM_I;  use_rs1 = 1'b1;
                dec_ctrl.alu_op    = alu_from_funct(funct3, (funct3 == 3'b101) && ins[30]);
                dec_ctrl.alu_src   = 1'b1;  dec_ctrl.reg_write = 1'b1;
            end
            OPC_OP: begin
                use_rs1 = 1'b1;  use_rs2 = 1'b1;
                dec_ctrl.alu_op    = alu_from_funct(funct3, ins[30]);
                dec_ctrl.reg_write = 1'b1;
            end
            default: dec_ctrl.illegal = 1'b1;
        endcase
    end

    // Unused register fields are zeroed so EX forwarding never matches stray bits.
    assign rs1_addr = use_rs1 ? ins[19:15] : 5'd0;
    assign rs2_addr = use_rs2 ? ins[24:20] : 5'd0;
    assign rd_addr  = dec_ctrl.reg_write ? ins[11:7] : 5'd0;
    assign imm      = gen_imm(ins, imm_fmt);

    regfile u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (wb_reg_write),
        .waddr  (wb_rd),
        .wdata  (wb_data),
        .raddr1 (rs1_addr),
        .rdata1 (rs1_data),
        .raddr2 (rs2_addr),
        .rdata2 (rs2_data)
    );

    // A load in EX whose destination feeds this instruction must wait one cycle.
    assign load_use_stall = ex_ctrl.mem_read && (id_ex_rd != 5'd0) &&
                            ((use_rs1 && (ins[19:15] == id_ex_rd)) ||
                             (use_rs2 && (ins[24:20] == id_ex_rd)));

    assign squash = id_flush || load_use_stall;

    // ID/EX register: reset/bubble, hold on mem_stall, otherwise capture decode.
    always_ff @(posedge clk) begin
        if (rst || (!mem_stall && squash)) begin
            id_ex_pc       <= RESET_PC_PLUS4;
            id_ex_rs1_data <= '0;
            id_ex_rs2_data <= '0;
            id_ex_imm      <= '0;
            id_ex_rs1      <= '0;
            id_ex_rs2      <= '0;
            id_ex_rd       <= '0;
            ex_ctrl        <= '0;
        end else if (!mem_stall) begin
            id_ex_pc       <= if_id_pc;
            id_ex_rs1_data <= rs1_data;
            id_ex_rs2_data <= rs2_data;
            id_ex_imm      <= imm;
            id_ex_rs1      <= rs1_addr;
            id_ex_rs2      <= rs2_addr;
            id_ex_rd       <= rd_addr;
            ex_ctrl        <= dec_ctrl;
        end
    end

    assign id_ex_alu_op     = ex_ctrl.alu_op;
    assign id_ex_alu_src    = ex_ctrl.alu_src;
    assign id_ex_mem_read   = ex_ctrl.mem_read;
    assign id_ex_mem_write  = ex_ctrl.mem_write;
    assign id_ex_reg_write  = ex_ctrl.reg_write;
    assign id_ex_mem_to_reg = ex_ctrl.mem_to_reg;
    assign id_ex_branch     = ex_ctrl.branch;
    assign id_ex_jump       = ex_ctrl.jump;
    assign id_ex_illegal    = ex_ctrl.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: decode vector table, hazard/stall/reset sequences and a
// randomized run against an instruction-level reference model.
module tb_id_stage;
    import id_stage_pkg::*;

    localparam logic [31:0] RPC = 32'h00000004;
    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [3:0]  ALU_TAB [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU,
                                            ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_id_pc, if_id_instruction, wb_data;
    logic        mem_stall, id_flush, wb_reg_write;
    logic [4:0]  wb_rd;
    logic        load_use_stall;
    logic [31:0] id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm;
    logic [4:0]  id_ex_rs1, id_ex_rs2, id_ex_rd;
    logic [3:0]  id_ex_alu_op;
    logic        id_ex_alu_src, id_ex_mem_read, id_ex_mem_write, id_ex_reg_write;
    logic        id_ex_mem_to_reg, id_ex_branch, id_ex_jump, id_ex_illegal;

    always #5 clk = ~clk;

    id_stage #(.RESET_PC_PLUS4(RPC)) dut (
        .clk(clk), .rst(rst), .if_id_pc(if_id_pc), .if_id_instruction(if_id_instruction),
        .mem_stall(mem_stall), .id_flush(id_flush), .wb_reg_write(wb_reg_write),
        .wb_rd(wb_rd), .wb_data(wb_data), .load_use_stall(load_use_stall),
        .id_ex_pc(id_ex_pc), .id_ex_rs1_data(id_ex_rs1_data), .id_ex_rs2_data(id_ex_rs2_data),
        .id_ex_imm(id_ex_imm), .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
        .id_ex_alu_op(id_ex_alu_op), .id_ex_alu_src(id_ex_alu_src),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_mem_write(id_ex_mem_write),
        .id_ex_reg_write(id_ex_reg_write), .id_ex_mem_to_reg(id_ex_mem_to_reg),
        .id_ex_branch(id_ex_branch), .id_ex_jump(id_ex_jump), .id_ex_illegal(id_ex_illegal)
    );

    // ctrl bits: {alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch, jump, illegal}
    typedef struct packed {
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  alu;
        logic [7:0]  ctrl;
    } st_t;

    typedef struct packed {
        logic [31:0] instr, imm;
        logic [4:0]  rd, rs1, rs2;
        logic [3:0]  alu;
        logic [7:0]  ctrl;
    } vec_t;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] mregs [32];
    st_t         exp_st;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    function automatic logic [7:0] dut_ctrl();
        return {id_ex_alu_src, id_ex_mem_read, id_ex_mem_write, id_ex_reg_write,
                id_ex_mem_to_reg, id_ex_branch, id_ex_jump, id_ex_illegal};
    endfunction

    task automatic cmp_st(input string tag, input st_t e);
        chk({tag, ".pc"},   id_ex_pc,       e.pc);
        chk({tag, ".rs1d"}, id_ex_rs1_data, e.rs1d);
        chk({tag, ".rs2d"}, id_ex_rs2_data, e.rs2d);
        chk({tag, ".imm"},  id_ex_imm,      e.imm);
        chk({tag, ".rs1"},  32'(id_ex_rs1), 32'(e.rs1));
        chk({tag, ".rs2"},  32'(id_ex_rs2), 32'(e.rs2));
        chk({tag, ".rd"},   32'(id_ex_rd),  32'(e.rd));
        chk({tag, ".alu"},  32'(id_ex_alu_op), 32'(e.alu));
        chk({tag, ".ctrl"}, 32'(dut_ctrl()), 32'(e.ctrl));
    endtask

    function automatic st_t bubble();
        st_t b = '0;
        b.pc = RPC;
        return b;
    endfunction

    // Reference decode from the ISA tables; source fields not used stay 0.
    function automatic st_t mdl_dec(input logic [31:0] ins, input logic [31:0] pc);
        st_t d = '0;
        logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
        logic [2:0]  f3;
        f3    = ins[14:12];
        i_imm = 32'($signed(ins[31:20]));
        s_imm = 32'($signed({ins[31:25], ins[11:7]}));
        b_imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8]})) << 1;
        u_imm = {ins[31:12], 12'h000};
        j_imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21]})) << 1;
        d.pc  = pc;
        case (ins[6:0])
            OPC_LUI:    begin d.imm = u_imm; d.rd = ins[11:7]; d.alu = ALU_PASS_B; d.ctrl = 8'b1001_0000; end
            OPC_AUIPC:  begin d.imm = u_imm; d.rd = ins[11:7]; d.alu = ALU_ADD; d.ctrl = 8'b1001_0000; end
            OPC_JAL:    begin d.imm = j_imm; d.rd = ins[11:7]; d.alu = ALU_ADD; d.ctrl = 8'b0001_0010; end
            OPC_JALR:   begin d.imm = i_imm; d.rd = ins[11:7]; d.rs1 = ins[19:15];
                              d.alu = ALU_ADD; d.ctrl = 8'b1001_0010; end
            OPC_BRANCH: begin d.imm = b_imm; d.rs1 = ins[19:15]; d.rs2 = ins[24:20];
                              d.alu = ALU_SUB; d.ctrl = 8'b0000_0100; end
            OPC_LOAD:   begin d.imm = i_imm; d.rd = ins[11:7]; d.rs1 = ins[19:15];
                              d.alu = ALU_ADD; d.ctrl = 8'b1101_1000; end
            OPC_STORE:  begin d.imm = s_imm; d.rs1 = ins[19:15]; d.rs2 = ins[24:20];
                              d.alu = ALU_ADD; d.ctrl = 8'b1010_0000; end
            OPC_OP_IMM: begin d.imm = i_imm; d.rd = ins[11:7]; d.rs1 = ins[19:15];
                              d.alu = (f3 == 3'd5 && ins[30]) ? ALU_SRA : ALU_TAB[f3];
                              d.ctrl = 8'b1001_0000; end
            OPC_OP:     begin d.rd = ins[11:7]; d.rs1 = ins[19:15]; d.rs2 = ins[24:20];
                              d.alu = (ins[30] && f3 == 3'd0) ? ALU_SUB :
                                      (ins[30] && f3 == 3'd5) ? ALU_SRA : ALU_TAB[f3];
                              d.ctrl = 8'b0001_0000; end
            default:    d.ctrl = 8'b0000_0001;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] mrd(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (wb_reg_write && wb_rd == a) return wb_data;
        return mregs[a];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [31:0] ins, input logic [31:0] pc, input logic ms, input logic fl);
        if_id_instruction = ins;
        if_id_pc          = pc;
        mem_stall         = ms;
        id_flush          = fl;
    endtask

    task automatic wb(input logic we, input logic [4:0] rd, input logic [31:0] data);
        wb_reg_write = we;
        wb_rd        = rd;
        wb_data      = data;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drv(NOP, 32'h0, 1'b0, 1'b0);
        wb(1'b0, 5'd0, 32'h0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        exp_st = bubble();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  ops [10];
        ops = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
                OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP, 7'h00};
        r = $urandom;
        ops[9] = r[6:0];
        r[6:0]   = ops[$urandom_range(0, 9)];
        r[11:9]  = 3'b000;   // keep rd, rs1, rs2 in x0..x3 to provoke hazards
        r[19:17] = 3'b000;
        r[24:22] = 3'b000;
        return r;
    endfunction

    vec_t vecs [14];
    st_t  e;

    initial begin
        vecs = '{
            '{32'h00500093, 32'h00000005, 5'd1, 5'd0, 5'd0, ALU_ADD,    8'b1001_0000},
            '{32'h123452B7, 32'h12345000, 5'd5, 5'd0, 5'd0, ALU_PASS_B, 8'b1001_0000},
            '{32'hFFFFF317, 32'hFFFFF000, 5'd6, 5'd0, 5'd0, ALU_ADD,    8'b1001_0000},
            '{32'hFFDFF0EF, 32'hFFFFFFFC, 5'd1, 5'd0, 5'd0, ALU_ADD,    8'b0001_0010},
            '{32'h00008067, 32'h00000000, 5'd0, 5'd1, 5'd0, ALU_ADD,    8'b1001_0010},
            '{32'hFE000CE3, 32'hFFFFFFF8, 5'd0, 5'd0, 5'd0, ALU_SUB,    8'b0000_0100},
            '{32'h0021A623, 32'h0000000C, 5'd0, 5'd3, 5'd2, ALU_ADD,    8'b1010_0000},
            '{32'hFFC12383, 32'hFFFFFFFC, 5'd7, 5'd2, 5'd0, ALU_ADD,    8'b1101_1000},
            '{32'h001101B3, 32'h00000000, 5'd3, 5'd2, 5'd1, ALU_ADD,    8'b0001_0000},
            '{32'h40218233, 32'h00000000, 5'd4, 5'd3, 5'd2, ALU_SUB,    8'b0001_0000},
            '{32'h4030D293, 32'h00000403, 5'd5, 5'd1, 5'd0, ALU_SRA,    8'b1001_0000},
            '{32'h0020B333, 32'h00000000, 5'd6, 5'd1, 5'd2, ALU_SLTU,   8'b0001_0000},
            '{32'hFFFFFFFF, 32'h00000000, 5'd0, 5'd0, 5'd0, 4'h0,       8'b0000_0001},
            '{32'hFFF0F113, 32'hFFFFFFFF, 5'd2, 5'd1, 5'd0, ALU_AND,    8'b1001_0000}
        };

        // Reset state
        do_reset();
        cmp_st("reset", bubble());
        chk("reset.stall", 32'(load_use_stall), 32'd0);

        // Decode table, one instruction per cycle, no hazards along the way
        for (int i = 0; i < 14; i++) begin
            drv(vecs[i].instr, 32'h100 + 32'(4 * i), 1'b0, 1'b0);
            #1;
            chk($sformatf("vec%0d.stall", i), 32'(load_use_stall), 32'd0);
            tick();
            chk($sformatf("vec%0d.pc", i),   id_ex_pc, 32'h100 + 32'(4 * i));
            chk($sformatf("vec%0d.imm", i),  id_ex_imm, vecs[i].imm);
            chk($sformatf("vec%0d.rd", i),   32'(id_ex_rd),  32'(vecs[i].rd));
            chk($sformatf("vec%0d.rs1", i),  32'(id_ex_rs1), 32'(vecs[i].rs1));
            chk($sformatf("vec%0d.rs2", i),  32'(id_ex_rs2), 32'(vecs[i].rs2));
            chk($sformatf("vec%0d.alu", i),  32'(id_ex_alu_op), 32'(vecs[i].alu));
            chk($sformatf("vec%0d.ctrl", i), 32'(dut_ctrl()), 32'(vecs[i].ctrl));
        end

        // Load-use: lw x2,0(x1) then add x3,x2,x1 -> one bubble, then add
        do_reset();
        drv(32'h0000A103, 32'h10, 1'b0, 1'b0);
        #1 chk("lu.stall0", 32'(load_use_stall), 32'd0);
        tick();
        drv(32'h001101B3, 32'h14, 1'b0, 1'b0);
        #1 chk("lu.stall1", 32'(load_use_stall), 32'd1);
        tick();
        cmp_st("lu.bubble", bubble());
        chk("lu.stall2", 32'(load_use_stall), 32'd0);
        tick();
        cmp_st("lu.add", mdl_dec(32'h001101B3, 32'h14));

        // Flush coinciding with load-use: single bubble, stall still reported
        do_reset();
        drv(32'h0000A103, 32'h10, 1'b0, 1'b0);
        tick();
        drv(32'h001101B3, 32'h14, 1'b0, 1'b1);
        #1 chk("fl.stall", 32'(load_use_stall), 32'd1);
        tick();
        cmp_st("fl.bubble", bubble());
        drv(32'h001101B3, 32'h14, 1'b0, 1'b0);
        tick();
        cmp_st("fl.add", mdl_dec(32'h001101B3, 32'h14));

        // Write-through bypass, and writes to x0 are dropped
        do_reset();
        wb(1'b1, 5'd5, 32'hDEADBEEF);
        drv(32'h00028313, 32'h20, 1'b0, 1'b0);
        tick();
        e = mdl_dec(32'h00028313, 32'h20);
        e.rs1d = 32'hDEADBEEF;
        cmp_st("byp", e);
        wb(1'b1, 5'd0, 32'h12345678);
        drv(32'h005003B3, 32'h24, 1'b0, 1'b0);
        tick();
        e = mdl_dec(32'h005003B3, 32'h24);
        e.rs2d = 32'hDEADBEEF;
        cmp_st("x0", e);

        // mem_stall for 3 cycles (flush in the middle) holds ID/EX; WB still writes
        do_reset();
        drv(32'h00500093, 32'h40, 1'b0, 1'b0);
        tick();
        e = mdl_dec(32'h00500093, 32'h40);
        cmp_st("ms.pre", e);
        drv(32'h001101B3, 32'h44, 1'b1, 1'b0);
        wb(1'b1, 5'd1, 32'h00000055);
        tick();
        cmp_st("ms.c1", e);
        wb(1'b0, 5'd0, 32'h0);
        id_flush = 1'b1;
        tick();
        cmp_st("ms.c2", e);
        id_flush = 1'b0;
        tick();
        cmp_st("ms.c3", e);
        mem_stall = 1'b0;
        tick();
        e = mdl_dec(32'h001101B3, 32'h44);
        e.rs2d = 32'h00000055;
        cmp_st("ms.post", e);

        // Illegal instruction, then reset mid-stream
        drv(32'hFFFFFFFF, 32'h48, 1'b0, 1'b0);
        tick();
        chk("ill.flag", 32'(id_ex_illegal), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cmp_st("ill.reset", bubble());
        chk("ill.stall", 32'(load_use_stall), 32'd0);

        // Randomized run against the reference model
        do_reset();
        for (int c = 0; c < 400; c++) begin
            st_t d;
            logic stall;
            drv(rand_instr(), $urandom & 32'hFFFF_FFFC,
                $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
            wb($urandom_range(0, 1) == 1, 5'($urandom_range(0, 5)), $urandom);
            #1;
            d = mdl_dec(if_id_instruction, if_id_pc);
            stall = exp_st.ctrl[6] && exp_st.rd != 5'd0 &&
                    (exp_st.rd == d.rs1 || exp_st.rd == d.rs2);
            chk($sformatf("rnd%0d.stall", c), 32'(load_use_stall), 32'(stall));
            d.rs1d = mrd(d.rs1);
            d.rs2d = mrd(d.rs2);
            if (!mem_stall) exp_st = (id_flush || stall) ? bubble() : d;
            if (wb_reg_write && wb_rd != 5'd0) mregs[wb_rd] = wb_data;
            tick();
            cmp_st($sformatf("rnd%0d", c), exp_st);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC_PLUS4, default 32'h00000004, meaning the id_ex_pc value loaded on reset and bubble.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port if_id_pc  input  32  PC+4 of the instruction being decoded.
REQ-005 The block SHALL have port if_id_instruction  input  32  instruction being decoded.
REQ-006 The block SHALL have port mem_stall  input  1  global freeze; holds ID/EX register.
REQ-007 The block SHALL have port id_flush  input  1  taken branch/jump from EX; squashes the decoded instruction.
REQ-008 The block SHALL have ports wb_reg_write (input, 1), wb_rd (input, 5) and wb_data (input, 32), meaning the register-file write port from WB.
REQ-009 The block SHALL have port load_use_stall  output  1  combinational hazard request driving pc_stall and id_stall upstream.
REQ-010 The block SHALL have ports id_ex_pc (32), id_ex_rs1_data (32), id_ex_rs2_data (32), id_ex_imm (32), id_ex_rs1 (5), id_ex_rs2 (5) and id_ex_rd (5), all outputs, meaning registered ID/EX datapath fields.
REQ-011 The block SHALL have ports id_ex_alu_op (4), id_ex_alu_src, id_ex_mem_read, id_ex_mem_write, id_ex_reg_write, id_ex_mem_to_reg, id_ex_branch, id_ex_jump and id_ex_illegal (1 each), all outputs, meaning registered control fields.

Function
REQ-012 The decoder SHALL decode RV32I opcodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM and OP.
REQ-013 An unknown opcode SHALL decode as a NOP with all control fields 0 and id_ex_illegal=1.
REQ-014 The immediate SHALL be sign-extended per the I, S, B, U or J format; B and J immediates SHALL have bit 0 forced to 0.
REQ-015 The register file SHALL hold 32x32 bits and be written on clk when wb_reg_write=1 and wb_rd!=0.
REQ-016 Register x0 SHALL always read 0.
REQ-017 A same-cycle write to a register being read SHALL bypass: when wb_reg_write=1, wb_rd!=0 and wb_rd equals the read address, the read returns wb_data.
REQ-018 load_use_stall SHALL be 1 when id_ex_mem_read=1, id_ex_rd!=0, and id_ex_rd matches a source register the current opcode actually uses.
REQ-019 ID/EX update priority SHALL be, in order: rst > mem_stall (hold all fields) > (id_flush OR load_use_stall) (load bubble) > load decoded values.
REQ-020 A bubble SHALL clear all control fields and id_ex_illegal, set the data fields to 0, and set id_ex_pc to RESET_PC_PLUS4.
REQ-021 Decode-to-ID/EX latency SHALL be 1 cycle.
REQ-022 The register file SHALL still accept a WB write while mem_stall, load_use_stall or id_flush is active.
REQ-023 id_flush together with load_use_stall SHALL produce a single bubble, and load_use_stall SHALL still be reported.

Reset
REQ-024 On rst the ID/EX register SHALL take bubble values (REQ-020).
REQ-025 Register-file contents SHALL be cleared to 0 on rst.
REQ-026 load_use_stall SHALL be 0 in any cycle in which the ID/EX register holds reset values.

Structure
REQ-027 Opcode constants, immediate-format codes and the alu_op encoding SHALL reside in the shared pipeline definitions package.
REQ-028 The register file SHALL be the sub-module regfile, with 2 combinational read ports and 1 synchronous write port.

Verification
REQ-029 Scenario: after reset, drive 0x00500093 (addi x1,x0,5) -> next cycle id_ex_imm=5, id_ex_rd=1, id_ex_reg_write=1, id_ex_alu_src=1.
REQ-030 Scenario: drive 0x0000A103 (lw x2,0(x1)) then 0x001101B3 (add x3,x2,x1) -> load_use_stall=1 for exactly 1 cycle and ID/EX holds a bubble; add is registered the following cycle.
REQ-031 Scenario: drive 0xFE000CE3 (beq x0,x0,-8) -> id_ex_imm=0xFFFFFFF8, id_ex_branch=1, id_ex_reg_write=0.
REQ-032 Scenario: wb write x5=0xDEADBEEF in the same cycle as a decode reading x5 -> id_ex_rs1_data=0xDEADBEEF; a wb write to x0 is ignored and x0 reads 0.
REQ-033 Scenario: mem_stall=1 for 3 cycles with id_flush=1 in the middle cycle -> ID/EX is unchanged throughout.
REQ-034 Scenario: drive 0xFFFFFFFF, then assert rst mid-stream -> id_ex_illegal=1, then all outputs return to reset values one cycle after rst.
